// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the round-robin shared BCD converter.
package bcd_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int               DIGIT_W     = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VAL    = 4'd3;
    localparam logic [DIGIT_W-1:0] BLANK_CODE  = 4'hF;

    // Double-dabble digit correction applied before every shift.
    function automatic logic [DIGIT_W-1:0] dabble_adj(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if (d >= ADD3_THRESH) begin
            r = d + ADD3_VAL;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-facing bus of the shared BCD converter: level requests in, ack/result out.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 5,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*BIN_W-1:0] req_val;
    logic [NUM_REQ-1:0]       ack;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [DIGITS*4-1:0]      bcd_out;

    modport master (
        output req, req_val,
        input  ack, busy, done, done_id, bcd_out
    );

    modport slave (
        input  req, req_val,
        output ack, busy, done, done_id, bcd_out
    );
endinterface

// File: rtl/bcd_dabble_seq.sv
// Iterative double-dabble engine: load a binary value, then one add-3/shift step per cycle.
module bcd_dabble_seq
    import bcd_arb_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic                        i_step,
    input  logic [BIN_W-1:0]            i_bin,
    output logic [DIGITS*DIGIT_W-1:0]   o_bcd_next,
    output logic                        o_last
);
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    logic [BCD_W-1:0]       r_bcd;
    logic [BIN_W-1:0]       r_bin;
    logic [CNT_W-1:0]       r_cnt;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;

    // Per-nibble add-3 correction of the current BCD field.
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[k*DIGIT_W +: DIGIT_W] = dabble_adj(r_bcd[k*DIGIT_W +: DIGIT_W]);
        end
    end

    assign w_shift    = {w_adj, r_bin} << 1;
    assign o_bcd_next = w_shift[BIN_W +: BCD_W];
    assign o_last     = (r_cnt == CNT_W'(BIN_W - 1));

    // Shift register and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_bcd <= '0;
            r_bin <= i_bin;
            r_cnt <= '0;
        end else if (i_step) begin
            r_bcd <= o_bcd_next;
            r_bin <= w_shift[BIN_W-1:0];
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end else begin
            r_bcd <= r_bcd;
            r_bin <= r_bin;
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one iterative binary-to-BCD converter among NUM_REQ requesters.
// Optional build macro BCD_LEADING_BLANK_EN blanks leading zero digits (code 4'hF) in the result.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 5,
    parameter int ID_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_conv_arbiter_if.slave bus
);
    localparam int BCD_W = DIGITS * DIGIT_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_done_id;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_vld;
    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic               w_last;
    logic [NUM_REQ-1:0] w_req_rot;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;
    logic               r_done;
    logic [BIN_W-1:0]   w_sel_val;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BCD_W-1:0]   r_bcd_out;

    // Explicit modulo keeps the pointer inside the populated range for any NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [BCD_W-1:0] fmt_result(input logic [BCD_W-1:0] d);
`ifdef BCD_LEADING_BLANK_EN
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (d[k*DIGIT_W +: DIGIT_W] == 4'd0)) begin
                r[k*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
`else
        return d;
`endif
    endfunction

    assign w_req_rot = NUM_REQ'({bus.req, bus.req} >> r_rr);

    // First requester at or above the rr pointer, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_vld && w_req_rot[i]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = rr_index(r_rr, i);
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // Value mux and one-hot ack for the granted requester.
    always_comb begin
        w_sel_val = '0;
        w_ack_nxt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_sel_val    = bus.req_val[k*BIN_W +: BIN_W];
                w_ack_nxt[k] = w_load;
            end else begin
                w_ack_nxt[k] = 1'b0;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = CONV;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CONV: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = CONV;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping, handshake pulses and the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr      <= '0;
            r_id      <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_bcd_out <= '0;
        end else begin
            r_ack  <= w_ack_nxt;
            r_done <= w_finish;
            if (w_load) begin
                r_busy <= 1'b1;
                r_rr   <= rr_index(w_grant_idx, 1);
                r_id   <= w_grant_idx;
            end else if (w_finish) begin
                r_busy    <= 1'b0;
                r_bcd_out <= fmt_result(w_bcd_next);
                r_done_id <= r_id;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    bcd_dabble_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_bin      (w_sel_val),
        .o_bcd_next (w_bcd_next),
        .o_last     (w_last)
    );

    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.bcd_out = r_bcd_out;

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one iterative double-dabble binary-to-BCD converter among NUM_REQ requesters, e.g. frequency, peak-amplitude and RMS display readouts.
- Arbitration is round-robin, and the converter handles one conversion at a time.
- Each conversion takes BIN_W shift cycles instead of a wide combinational chain, which saves LUTs and eases timing ahead of the 7-segment/LCD display driver.
- Each result is returned with the identity of the requester that submitted it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIN_W, 16, binary input width.
- DIGITS, 5, BCD digits out; DIGITS*4 must hold 2^BIN_W-1.
- ID_W, 3, width of requester index (must be >= clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until its ack.
- req_val  in  NUM_REQ*BIN_W  packed binary values; requester k uses slice [k*BIN_W +: BIN_W].
- ack  out  NUM_REQ  one-cycle pulse: value of requester k captured.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bcd_out/done_id valid.
- done_id  out  ID_W  requester index of the current result.
- bcd_out  out  DIGITS*4  packed digits, most significant digit in the top nibble; holds last result.

Behaviour:
- Reset: rst_n=0 sampled at a clk edge clears everything.
  - State -> IDLE, rr pointer -> 0, ack/done/busy -> 0, done_id -> 0, bcd_out -> 0, shift register and bit counter -> 0.
  - A reset mid-conversion aborts it: no done and no result.
- State machine, IDLE / CONV:
  - IDLE: if any req is high in cycle T, grant k, the first set bit searching upward from the rr pointer (wrapping).
  - At edge T: capture slice k, clear the BCD field, cnt <= 0, state -> CONV, busy <= 1, ack[k] <= 1 for cycle T+1 only, rr pointer <= (k+1) mod NUM_REQ, latch id k.
  - CONV: each cycle, every BCD nibble >= 5 gets +3 (mod 16), then the whole {bcd, bin} register shifts left by 1; cnt increments.
  - On the cycle where cnt == BIN_W-1 (cycle T+BIN_W): after the shift, register bcd_out, done <= 1, done_id <= id, busy <= 0, state -> IDLE.
- Latency:
  - Request sampled at T; done high in cycle T+BIN_W+1 (T+17 at default).
  - Earliest next capture is at edge T+17, so back-to-back spacing is BIN_W+1 cycles.
- Handshake:
  - A requester drops req in the cycle it sees ack.
  - If req is still high at the next IDLE evaluation, it is treated as a new request.
  - req is ignored while busy; no queueing beyond the level request.
- Simultaneous events:
  - All requests asserted: grant order follows the rr pointer, so every requester is served within NUM_REQ conversions.
  - done and a new capture can occur on the same edge (IDLE entered at T+17).
- Boundary values:
  - Input 0 gives all-zero digits.
  - Input 2^BIN_W-1 gives 65535 at default.
  - NUM_REQ not a power of two: rr wrap uses explicit mod, and non-existent indices are never granted.
- Output stability: bcd_out and done_id stay stable until the next done.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: at the result-register stage, leading zero digits above the least significant are replaced by 4'hF (blank code for the display decoder).
  - Example: 0 gives F,F,F,F,0; 120 gives F,F,1,2,0.
  - Latency is unchanged.
- Undefined: raw digits with leading zeros.

Decomposition:
- Package bcd_arb_pkg:
  - state enum {IDLE, CONV}.
  - DIGIT_W=4, ADD3_THRESH=4'd5, ADD3_VAL=4'd3, BLANK_CODE=4'hF.
- Sub-module bcd_dabble_seq: load/step interface, holds the shift register and counter, and flags last step.
- The arbiter top owns the rr pointer, FSM, ack/done generation and the result register.

Test Plan:
- req[0]=1 with 12345 at T -> ack[0] high at T+1 only, busy T+1..T+16, done at T+17, bcd_out=1,2,3,4,5, done_id=0.
- Single requests with 65535 and 0 -> 6,5,5,3,5 and 0,0,0,0,0; with BCD_LEADING_BLANK_EN, 0 gives F,F,F,F,0 and 907 gives F,F,9,0,7.
- All 4 req high together with values 10,20,30,40, each dropping on its ack -> done_ids 0,1,2,3 at T+17,T+34,T+51,T+68 with results 10,20,30,40.
- After a grant to 2, req[0] and req[3] both high -> next grant is 3, then 0.
- rst_n low at T+8 during a conversion -> no done, all outputs 0; a fresh req of 4096 afterwards converts normally (0,4,0,9,6).
- req[1] held high through its ack -> re-granted at edge T+17, done again at T+34; no ack while busy.
